sram_port_arbiter: RTL and testbench

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/sram_arb_pkg.sv | 25 ++
 rtl/sram_arb_rr.sv | 50 +++++
 rtl/sram_port_arbiter.sv | 95 +++++++++
 tb/tb_sram_port_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types for the two-host SRAM port arbiter: host index,
// host count and the registered response record.
package sram_arb_pkg;

    localparam int NumHosts = 2;

    typedef enum logic {
        HostData  = 1'b0,
        HostInstr = 1'b1
    } host_e;

    // One outstanding response: which host it belongs to and whether
    // it reports an out-of-range access instead of RAM data.
    typedef struct packed {
        logic  valid;
        host_e host;
        logic  err;
    } rsp_t;

    // The host that is not h; used to hand priority to the loser.
    function automatic host_e other_host(input host_e h);
        return (h == HostData) ? HostInstr : HostData;
    endfunction

endpackage

// File: rtl/sram_arb_rr.sv
// Two-way round-robin picker. A sole requester always wins; on contention
// the host named by prio_q wins and priority moves to the loser.
module sram_arb_rr
    import sram_arb_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumHosts-1:0] req,
    output logic [NumHosts-1:0] gnt,
    output logic                gnt_valid,
    output host_e               gnt_host
);

    host_e prio_q;
    host_e prio_d;

    // Pick the winner and compute the next priority.
    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // case leaves a variable unassigned, which would infer a latch.
        gnt_host = HostData;
        prio_d   = prio_q;
        gnt      = '0;
        unique case (req)
            2'b01: gnt_host = HostData;
            2'b10: gnt_host = HostInstr;
            2'b11: begin
                gnt_host = prio_q;
                prio_d   = other_host(prio_q);
            end
            default: gnt_host = HostData;
        endcase
        gnt_valid = |req;
        if (gnt_valid) begin
            gnt[gnt_host] = 1'b1;
        end
    end

    // Priority register; only contended grants move it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= HostData;
        end else begin
            // NOTE: non-blocking so the flop samples the pre-edge value of
            // prio_d, independent of process evaluation order.
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates a data host and an instruction host onto one single-port SRAM.
// Grants are combinational, responses arrive exactly one cycle later, and
// accesses outside the RAM window complete with an error response.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned MemSize  = 262144,
    parameter logic [31:0] MemStart = 32'h0000_0000,
    localparam int unsigned AddrW   = $clog2(MemSize / 4)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NumHosts-1:0]        req_i,
    input  logic [NumHosts-1:0]        we_i,
    input  logic [NumHosts-1:0][3:0]   be_i,
    input  logic [NumHosts-1:0][31:0]  addr_i,
    input  logic [NumHosts-1:0][31:0]  wdata_i,
    output logic [NumHosts-1:0]        gnt_o,
    output logic [NumHosts-1:0]        rvalid_o,
    output logic [NumHosts-1:0][31:0]  rdata_o,
    output logic [NumHosts-1:0]        err_o,
    output logic                       ram_req_o,
    output logic                       ram_we_o,
    output logic [3:0]                 ram_be_o,
    output logic [AddrW-1:0]           ram_addr_o,
    output logic [31:0]                ram_wdata_o,
    input  logic [31:0]                ram_rdata_i
);

    localparam logic [31:0] MemMask = MemSize - 1;

    logic [NumHosts-1:0] req_gated;
    logic                gnt_valid;
    host_e               gnt_host;
    logic [31:0]         sel_addr;
    logic                in_range;
    rsp_t                rsp_q;

    // No grant can be issued while reset is held.
    assign req_gated = req_i & {NumHosts{rst_ni}};

    sram_arb_rr u_rr (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req       (req_gated),
        .gnt       (gnt_o),
        .gnt_valid (gnt_valid),
        .gnt_host  (gnt_host)
    );

    assign sel_addr = addr_i[gnt_host];
    assign in_range = (sel_addr & ~MemMask) == MemStart;

    // Forward the granted in-range access to the RAM; idle bus is all zero.
    always_comb begin
        ram_req_o   = 1'b0;
        ram_we_o    = 1'b0;
        ram_be_o    = '0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        if (gnt_valid && in_range) begin
            ram_req_o   = 1'b1;
            ram_we_o    = we_i[gnt_host];
            ram_be_o    = be_i[gnt_host];
            ram_addr_o  = sel_addr[AddrW+1:2];
            ram_wdata_o = wdata_i[gnt_host];
        end
    end

    // Response record: one entry per grant, retired the following cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_q <= '0;
        end else begin
            rsp_q.valid <= gnt_valid;
            rsp_q.host  <= gnt_host;
            rsp_q.err   <= gnt_valid && !in_range;
        end
    end

    // Steer the response to its host; error responses carry zero data.
    always_comb begin
        rvalid_o = '0;
        err_o    = '0;
        rdata_o  = '0;
        for (int h = 0; h < NumHosts; h++) begin
            if (rsp_q.valid && (int'(rsp_q.host) == h)) begin
                rvalid_o[h] = 1'b1;
                err_o[h]    = rsp_q.err;
                rdata_o[h]  = rsp_q.err ? 32'h0 : ram_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter (MemSize 256 kB, MemStart 0).
// Each step drives one cycle of requests, checks the combinational grant
// and RAM bus, and queues the response expected on the following cycle.
module tb_sram_port_arbiter;

    localparam int AddrW = 16;

    typedef struct {
        logic        valid;
        logic        host;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic [1:0]       req_i;
    logic [1:0]       we_i;
    logic [1:0][3:0]  be_i;
    logic [1:0][31:0] addr_i;
    logic [1:0][31:0] wdata_i;
    logic [1:0]       gnt_o;
    logic [1:0]       rvalid_o;
    logic [1:0][31:0] rdata_o;
    logic [1:0]       err_o;
    logic             ram_req_o;
    logic             ram_we_o;
    logic [3:0]       ram_be_o;
    logic [AddrW-1:0] ram_addr_o;
    logic [31:0]      ram_wdata_o;
    logic [31:0]      ram_rdata_i = 32'hFFFF_FFFF;

    exp_t sb[$];
    logic m_prio;
    int   n_cmp = 0;
    int   n_err = 0;

    sram_port_arbiter dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .we_i        (we_i),
        .be_i        (be_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .ram_req_o   (ram_req_o),
        .ram_we_o    (ram_we_o),
        .ram_be_o    (ram_be_o),
        .ram_addr_o  (ram_addr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Content of RAM word a, known to both the RAM model and the scoreboard.
    function automatic logic [31:0] ram_word(input logic [15:0] a);
        return 32'hD00D_0000 | {16'h0, a};
    endfunction

    // RAM model: read data valid one cycle after the request.
    always @(posedge clk_i) begin
        if (ram_req_o) ram_rdata_i <= ram_word(ram_addr_o);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of requests (called at a falling edge, ends at the next).
    task automatic step(input logic [1:0] req, input logic [1:0] we,
                        input logic [1:0][3:0] be, input logic [1:0][31:0] addr,
                        input logic [1:0][31:0] wdata);
        exp_t             e;
        exp_t             n;
        logic [1:0][31:0] er;
        logic             h;
        logic             inr;
        req_i = req; we_i = we; be_i = be; addr_i = addr; wdata_i = wdata;
        #1;
        // Response to the previous cycle's grant.
        if (sb.size() != 0) e = sb.pop_front();
        else e = '{default: '0};
        er = '0;
        if (e.valid) er[e.host] = e.err ? 32'h0 : e.rdata;
        check("rvalid", rvalid_o, e.valid ? (2'b01 << e.host) : 2'b00);
        check("err", err_o, (e.valid && e.err) ? (2'b01 << e.host) : 2'b00);
        check("rdata", rdata_o, er);
        // Reference arbitration.
        h = 1'b0;
        if (req == 2'b11) begin
            h = m_prio;
            m_prio = ~m_prio;
        end else if (req[1]) begin
            h = 1'b1;
        end
        inr = (addr[h][31:18] == 14'h0);
        check("gnt", gnt_o, (req == 2'b00) ? 2'b00 : (2'b01 << h));
        if (req != 2'b00 && inr) begin
            check("ram_req", ram_req_o, 1'b1);
            check("ram_we", ram_we_o, we[h]);
            check("ram_be", ram_be_o, be[h]);
            check("ram_addr", ram_addr_o, addr[h][17:2]);
            check("ram_wdata", ram_wdata_o, wdata[h]);
        end else begin
            check("ram_idle", {ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o}, 64'h0);
        end
        n.valid = (req != 2'b00);
        n.host  = h;
        n.err   = !inr;
        n.rdata = ram_word(addr[h][17:2]);
        sb.push_back(n);
        @(negedge clk_i);
    endtask

    task automatic idle();
        step(2'b00, 2'b00, '0, '0, '0);
    endtask

    task automatic do_reset();
        req_i  = '0;
        rst_ni = 1'b0;
        sb.delete();
        m_prio = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        logic [1:0]       r_req;
        logic [1:0]       r_we;
        logic [1:0][3:0]  r_be;
        logic [1:0][31:0] r_addr;
        logic [1:0][31:0] r_wdata;

        // Reset state, with both hosts requesting to prove grants are held off.
        rst_ni = 1'b0; m_prio = 1'b0;
        req_i = 2'b11; we_i = '0; be_i = '0; addr_i = '0; wdata_i = '0;
        #1;
        check("rst_gnt", gnt_o, 2'b00);
        check("rst_ram_req", ram_req_o, 1'b0);
        check("rst_rvalid", rvalid_o, 2'b00);
        check("rst_err", err_o, 2'b00);
        check("rst_rdata", rdata_o, 64'h0);
        req_i = '0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        // Data read of word 4, data write with partial strobes, instr out of range.
        step(2'b01, 2'b00, {4'h0, 4'hF}, {32'h0, 32'h0000_0010}, '0);
        step(2'b01, 2'b01, {4'h0, 4'b0011}, {32'h0, 32'h0000_0100}, {32'h0, 32'hA5A5_1234});
        step(2'b10, 2'b00, {4'hF, 4'h0}, {32'h0004_0000, 32'h0}, '0);
        idle();

        // Instr alone for three cycles leaves priority with data.
        for (int i = 0; i < 3; i++)
            step(2'b10, 2'b00, {4'hF, 4'h0}, {32'h20 + 32'(i * 4), 32'h0}, '0);
        step(2'b11, 2'b00, {4'hF, 4'hF}, {32'h0000_0040, 32'h0000_0044}, '0);
        idle();

        // Continuous contention from reset alternates data, instr, ...
        do_reset();
        for (int i = 0; i < 6; i++)
            step(2'b11, 2'b00, {4'hF, 4'hF}, {32'h1000 + 32'(i * 8), 32'h2000 + 32'(i * 8)}, '0);
        idle();

        // Reset during the response cycle drops it and restores data priority.
        step(2'b11, 2'b00, {4'hF, 4'hF}, {32'h300, 32'h304}, '0);
        #1;
        check("rsp_before_rst", rvalid_o, 2'b01);
        req_i  = 2'b11;
        rst_ni = 1'b0;
        #1;
        check("rst_mid_rvalid", rvalid_o, 2'b00);
        check("rst_mid_err", err_o, 2'b00);
        check("rst_mid_gnt", gnt_o, 2'b00);
        check("rst_mid_ram_req", ram_req_o, 1'b0);
        sb.delete();
        m_prio = 1'b0;
        req_i  = '0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        step(2'b11, 2'b00, {4'hF, 4'hF}, {32'h400, 32'h404}, '0);
        idle();

        // Random traffic, with occasional out-of-range addresses.
        for (int i = 0; i < 40; i++) begin
            r_req = 2'($urandom_range(0, 3));
            r_we  = 2'($urandom_range(0, 3));
            for (int k = 0; k < 2; k++) begin
                r_be[k]    = 4'($urandom_range(0, 15));
                r_wdata[k] = $urandom;
                r_addr[k]  = $urandom & 32'h0003_FFFC;
                if ($urandom_range(0, 5) == 0) r_addr[k] = r_addr[k] | 32'h0004_0000;
                if ($urandom_range(0, 9) == 0) r_addr[k] = r_addr[k] | 32'h8000_0000;
            end
            step(r_req, r_we, r_be, r_addr, r_wdata);
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
